// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing recovery: measures line/frame lengths from hsync/vsync,
// locks after consecutive identical frames and regenerates pixel coordinates.
module vga_sync_decoder #(
  parameter int unsigned HBP         = 144,
  parameter int unsigned VBP         = 31,
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned LOCK_FRAMES = 2
) (
  input  logic       dclk,
  input  logic       clr,
  input  logic       hsync,
  input  logic       vsync,
  output logic [9:0] x,
  output logic [9:0] y,
  output logic       active,
  output logic       frame_start,
  output logic       locked,
  output logic [9:0] h_total,
  output logic [9:0] v_total
);

  localparam int unsigned CW    = 10;
  localparam int unsigned CNT_W = 3;

  localparam logic [CW-1:0]    CNT_MAX = {CW{1'b1}};
  localparam logic [CW-1:0]    HBP_C   = CW'(HBP);
  localparam logic [CW-1:0]    H_END_C = CW'(HBP + H_ACTIVE);
  localparam logic [CW-1:0]    VBP_C   = CW'(VBP);
  localparam logic [CW-1:0]    V_END_C = CW'(VBP + V_ACTIVE);
  localparam logic [CNT_W-1:0] LOCK_C  = CNT_W'(LOCK_FRAMES);

  typedef enum logic [1:0] {SEARCH, CHECK, LOCKED} state_e;

  state_e           state_q, state_d;
  logic             hs_q, vs_q;
  logic [CW-1:0]    hc_q, hc_d;
  logic [CW-1:0]    vc_q, vc_d;
  logic [CW-1:0]    line_len_q, line_len_d;
  logic [CW-1:0]    line_ref_q, line_ref_d;
  logic             line_ok_q, line_ok_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CW-1:0]    h_total_q, h_total_d;
  logic [CW-1:0]    v_total_q, v_total_d;
  logic             frame_start_q;

  logic             hfall, vfall, timeout_c, win_c, frames_match_c;
  logic [CW-1:0]    line_len_c, frame_len_c;
  logic [CNT_W-1:0] cnt_n;

  // Edge detection, counters and per-frame line-length bookkeeping
  always_comb begin
    hfall       = hs_q & ~hsync;
    vfall       = vs_q & ~vsync;
    line_len_c  = hc_q + CW'(1);
    frame_len_c = vc_q + CW'(1);

    hc_d = (hc_q == CNT_MAX) ? CNT_MAX : hc_q + CW'(1);
    if (hfall) hc_d = '0;

    vc_d = vc_q;
    if (vfall)      vc_d = '0;
    else if (hfall) vc_d = (vc_q == CNT_MAX) ? CNT_MAX : vc_q + CW'(1);

    line_len_d = hfall ? line_len_c : line_len_q;
    timeout_c  = (hc_d == CNT_MAX);

    line_ref_d = line_ref_q;
    line_ok_d  = line_ok_q;
    if (vfall) begin
      line_ref_d = line_len_d;
      line_ok_d  = 1'b1;
    end else if (hfall && (line_len_c != line_ref_q)) begin
      line_ok_d = 1'b0;
    end
  end

  // Lock FSM; decisions at vfall use the statistics of the frame that just ended
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    h_total_d      = h_total_q;
    v_total_d      = v_total_q;
    cnt_n          = cnt_q;
    frames_match_c = line_ok_q && (line_ref_q == h_total_q) && (frame_len_c == v_total_q);
    case (state_q)
      SEARCH: begin
        if (vfall) begin
          state_d = CHECK;
          cnt_d   = '0;
        end
      end
      CHECK: begin
        if (timeout_c) begin
          state_d = SEARCH;
        end else if (vfall) begin
          if (cnt_q == '0) begin
            h_total_d = line_ref_q;
            v_total_d = frame_len_c;
            cnt_n     = line_ok_q ? CNT_W'(1) : '0;
          end else if (frames_match_c) begin
            cnt_n = cnt_q + CNT_W'(1);
          end else begin
            h_total_d = line_ref_q;
            v_total_d = frame_len_c;
            cnt_n     = '0;
          end
          cnt_d = cnt_n;
          if (cnt_n == LOCK_C) state_d = LOCKED;
        end
      end
      LOCKED: begin
        if ((hfall && !vfall && (line_len_c != h_total_q)) ||
            (vfall && (frame_len_c != v_total_q)) || timeout_c) begin
          state_d = SEARCH;
        end
      end
      default: state_d = SEARCH;
    endcase
  end

  always_ff @(posedge dclk or posedge clr) begin
    if (clr) begin
      state_q       <= SEARCH;
      hs_q          <= 1'b1;
      vs_q          <= 1'b1;
      hc_q          <= '0;
      vc_q          <= '0;
      line_len_q    <= '0;
      line_ref_q    <= '0;
      line_ok_q     <= 1'b0;
      cnt_q         <= '0;
      h_total_q     <= '0;
      v_total_q     <= '0;
      frame_start_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      hs_q          <= hsync;
      vs_q          <= vsync;
      hc_q          <= hc_d;
      vc_q          <= vc_d;
      line_len_q    <= line_len_d;
      line_ref_q    <= line_ref_d;
      line_ok_q     <= line_ok_d;
      cnt_q         <= cnt_d;
      h_total_q     <= h_total_d;
      v_total_q     <= v_total_d;
      frame_start_q <= vfall;
    end
  end

  // Coordinate decode straight from the registered counters and state
  always_comb begin
    locked      = (state_q == LOCKED);
    frame_start = frame_start_q;
    h_total     = h_total_q;
    v_total     = v_total_q;
    win_c       = (hc_q >= HBP_C) && (hc_q < H_END_C) && (vc_q >= VBP_C) && (vc_q < V_END_C);
    active      = locked && win_c;
    x           = active ? hc_q - HBP_C : '0;
    y           = active ? vc_q - VBP_C : '0;
  end

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Directed bench for vga_sync_decoder using a scaled-down 20x12 timing source.
module tb_vga_sync_decoder;

  localparam int HBP = 5;
  localparam int VBP = 3;
  localparam int HA  = 10;
  localparam int VA  = 6;
  localparam int HS  = 3;
  localparam int VS  = 2;
  localparam int LINE = 20;

  logic       clk = 1'b0;
  logic       clr, g_rst;
  logic       hsync, vsync;
  logic [9:0] x, y, h_total, v_total;
  logic       active, frame_start, locked;

  int g_hc, g_vc, cur_len;
  int frame_cfg    = 12;
  int stretch_line = -1;
  logic hold_h = 1'b0, hold_v = 1'b0;
  int passed = 0, total = 0;

  vga_sync_decoder #(.HBP(HBP), .VBP(VBP), .H_ACTIVE(HA), .V_ACTIVE(VA), .LOCK_FRAMES(2)) dut (
    .dclk(clk), .clr(clr), .hsync(hsync), .vsync(vsync),
    .x(x), .y(y), .active(active), .frame_start(frame_start), .locked(locked),
    .h_total(h_total), .v_total(v_total)
  );

  always #5 clk = ~clk;

  // Timing source: sync pulses at the start of each line/frame
  always_comb cur_len = (g_vc == stretch_line) ? LINE + 1 : LINE;
  assign hsync = hold_h ? 1'b1 : (g_hc >= HS);
  assign vsync = hold_v ? 1'b1 : (g_vc >= VS);

  always_ff @(posedge clk or posedge g_rst) begin
    if (g_rst) begin
      g_hc <= 0;
      g_vc <= VS;
    end else if (g_hc == cur_len - 1) begin
      g_hc <= 0;
      g_vc <= (g_vc >= frame_cfg - 1) ? 0 : g_vc + 1;
    end else begin
      g_hc <= g_hc + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  // Advance to the falling clock edge where the source sits at (h, v)
  task automatic goto(input int h, input int v);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(g_hc == h && g_vc == v) && n < 3000);
    chk("goto_bound", 32'(n < 3000), 32'd1);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, 32'(x), 0);
    chk({tag, "_y"}, 32'(y), 0);
    chk({tag, "_active"}, 32'(active), 0);
    chk({tag, "_fs"}, 32'(frame_start), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_htot"}, 32'(h_total), 0);
    chk({tag, "_vtot"}, 32'(v_total), 0);
  endtask

  initial begin
    clr = 1'b1;
    g_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk_all_zero("reset");
    clr = 1'b0;
    g_rst = 1'b0;

    // Acquisition: vfall #1 -> CHECK, #2 -> store, #3 -> LOCKED
    goto(1, 0);
    chk("acq_fs1", 32'(frame_start), 1);
    chk("acq_lock1", 32'(locked), 0);
    goto(2, 0);
    chk("acq_fs_pulse", 32'(frame_start), 0);
    goto(1, 0);
    chk("acq_lock2", 32'(locked), 0);
    goto(0, 0);
    chk("acq_lock_pre", 32'(locked), 0);
    goto(1, 0);
    chk("acq_lock3", 32'(locked), 1);
    chk("acq_fs3", 32'(frame_start), 1);
    chk("acq_htot", 32'(h_total), LINE);
    chk("acq_vtot", 32'(v_total), 12);

    // Active window corners and edges
    goto(HBP, VBP);
    chk("left_edge_active", 32'(active), 0);
    goto(HBP + 1, VBP);
    chk("origin_x", 32'(x), 0);
    chk("origin_y", 32'(y), 0);
    chk("origin_active", 32'(active), 1);
    goto(HBP + HA, VBP + VA - 1);
    chk("last_x", 32'(x), HA - 1);
    chk("last_y", 32'(y), VA - 1);
    chk("last_active", 32'(active), 1);
    goto(HBP + HA + 1, VBP + VA - 1);
    chk("right_blank_active", 32'(active), 0);
    chk("right_blank_x", 32'(x), 0);
    goto(HBP + 1, VBP + VA);
    chk("bottom_blank_active", 32'(active), 0);
    chk("bottom_blank_y", 32'(y), 0);
    goto(HBP + 1, VBP - 1);
    chk("top_blank_active", 32'(active), 0);

    // One 21-clock line while locked
    stretch_line = 4;
    goto(0, 5);
    chk("stretch_pre", 32'(locked), 1);
    goto(1, 5);
    chk("stretch_drop", 32'(locked), 0);
    chk("stretch_active", 32'(active), 0);
    stretch_line = -1;
    goto(1, 0);
    chk("stretch_check", 32'(locked), 0);
    // A bad line during the first CHECK frame keeps the count at zero
    stretch_line = 4;
    goto(1, 5);
    stretch_line = -1;
    goto(1, 0);
    chk("lineok_store", 32'(locked), 0);
    goto(1, 0);
    chk("lineok_cnt1", 32'(locked), 0);
    goto(0, 0);
    chk("relock_pre", 32'(locked), 0);
    goto(1, 0);
    chk("relock", 32'(locked), 1);
    chk("relock_htot", 32'(h_total), LINE);

    // Syncs held high: hc saturates and the lock times out
    hold_h = 1'b1;
    hold_v = 1'b1;
    repeat (1022) @(negedge clk);
    chk("timeout_pre", 32'(locked), 1);
    @(negedge clk);
    chk("timeout_drop", 32'(locked), 0);
    chk("timeout_active", 32'(active), 0);
    repeat (200) @(negedge clk);
    chk("timeout_stay", 32'(locked), 0);
    goto(10, 5);
    hold_h = 1'b0;
    hold_v = 1'b0;
    goto(1, 0);
    chk("to_relock1", 32'(locked), 0);
    goto(1, 0);
    chk("to_relock2", 32'(locked), 0);
    goto(1, 0);
    chk("to_relock3", 32'(locked), 1);

    // Shorter frames after lock
    goto(1, 5);
    frame_cfg = 11;
    goto(0, 0);
    chk("short_pre", 32'(locked), 1);
    goto(1, 0);
    chk("short_drop", 32'(locked), 0);
    goto(1, 0);
    chk("short_check", 32'(locked), 0);
    goto(1, 0);
    chk("short_cnt1", 32'(locked), 0);
    goto(1, 0);
    chk("short_relock", 32'(locked), 1);
    chk("short_vtot", 32'(v_total), 11);
    chk("short_htot", 32'(h_total), LINE);

    // Reset mid-frame while locked
    goto(HBP + 3, VBP + 1);
    chk("mid_active", 32'(active), 1);
    chk("mid_x", 32'(x), 2);
    chk("mid_y", 32'(y), 1);
    #1;
    clr = 1'b1;
    #1;
    chk_all_zero("clr");
    repeat (2) @(negedge clk);
    clr = 1'b0;
    goto(1, 0);
    chk("clr_acq1", 32'(locked), 0);
    goto(1, 0);
    chk("clr_acq2", 32'(locked), 0);
    goto(0, 0);
    chk("clr_acq_pre", 32'(locked), 0);
    goto(1, 0);
    chk("clr_relock", 32'(locked), 1);
    chk("clr_vtot", 32'(v_total), 11);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side VGA timing recovery. The block samples the `hsync`/`vsync` pair produced by the team's 640x480 VGA timing generator, or by any source with the same polarity, on the pixel clock. It measures line and frame lengths, declares lock after consecutive identical frames, and regenerates pixel coordinates and an active-video flag. It sits downstream of the sync generator in loopback tests and at the front of the capture/overlay path.

## Interface
- `HBP`, 144: pixel clocks from the hsync falling edge to the first active pixel
- `VBP`, 31: lines from the vsync falling edge to the first active line
- `H_ACTIVE`, 640: active pixels per line
- `V_ACTIVE`, 480: active lines per frame
- `LOCK_FRAMES`, 2: consecutive matching frames required to lock (1..7)

- `dclk`  in  1  pixel clock, 25 MHz; all logic on rising edge
- `clr`  in  1  reset, asynchronous, active-high
- `hsync`  in  1  horizontal sync, active-low pulse
- `vsync`  in  1  vertical sync, active-low pulse
- `x`  out  10  recovered column, 0..H_ACTIVE-1 while `active`, else 0
- `y`  out  10  recovered row, 0..V_ACTIVE-1 while `active`, else 0
- `active`  out  1  locked and inside the active window
- `frame_start`  out  1  one-cycle pulse on each detected vsync falling edge
- `locked`  out  1  timing stable
- `h_total`  out  10  locked line length in clocks
- `v_total`  out  10  locked frame length in lines

## Operation
- Input registers `hs_r`/`vs_r` sample `hsync`/`vsync`; both reset to 1.
- Edge detection:
  - `hfall = hs_r & ~hsync`
  - `vfall = vs_r & ~vsync`
- Horizontal counter `hc` (10 bit):
  - `hfall` → 0.
  - Otherwise +1, saturating at 1023.
  - Reaching 1023 is a timeout.
- Vertical counter `vc` (10 bit):
  - `vfall` → 0. Takes priority when `hfall` occurs in the same cycle.
  - Else `hfall` → +1, saturating at 1023.
- Measurements:
  - On `hfall`: `line_len = hc+1`.
  - On `vfall`: `frame_len = vc+1`.
- Per-frame consistency:
  - On `vfall`, `line_ref = line_len` and `line_ok = 1`.
  - On each `hfall` without `vfall`, if `line_len != line_ref` then `line_ok = 0`.
- Lock FSM, states SEARCH, CHECK, LOCKED:
  - SEARCH: on `vfall` → CHECK with `cnt=0`.
  - CHECK, on `vfall`:
    - If `cnt==0`: store `h_total=line_ref`, `v_total=frame_len`; `cnt=1` if `line_ok`, else stay at 0.
    - If `cnt>0`: `line_ok` and lengths equal to the stored values → `cnt+1`. Otherwise re-store the values and set `cnt=0`.
    - When `cnt` would reach `LOCK_FRAMES` → LOCKED.
  - LOCKED → SEARCH on any of:
    - `hfall` with `line_len != h_total`, except the `hfall` coincident with `vfall`;
    - `vfall` with `frame_len != v_total`;
    - timeout.
  - Timeout in CHECK also → SEARCH.
- `locked = (state==LOCKED)`.
- `h_total`/`v_total` hold their last stored values and reset to 0.
- `active = locked & HBP<=hc<HBP+H_ACTIVE & VBP<=vc<VBP+V_ACTIVE`.
- `x = hc-HBP` and `y = vc-VBP` when `active`, else 0.

## Timing
- Reset values:
  - `x=0`, `y=0`, `active=0`, `frame_start=0`, `locked=0`, `h_total=0`, `v_total=0`.
  - `hc=0`, `vc=0`, state SEARCH.
- All outputs are registered. `x`/`y`/`active` may be decoded from the registered counters and state.
- Counter latency: the decoder `hc` equals generator `hc-1`. Edge seen at edge k+1, when the generator changed its sync at edge k.
- Output latency: `x`/`y` match the generator's `X`/`Y` one clock later.
- `frame_start`: high exactly the cycle after the edge where `vfall` is sampled.
- Lock timing:
  - `locked` rises one cycle after the qualifying `vfall`.
  - It falls one cycle after the failing `hfall`/`vfall`/timeout.
  - `active` drops in that same cycle.
- Reset mid-frame: everything returns to reset values immediately. The first `vfall` after release restarts acquisition.

## Test plan
- Loopback from the 800x521 generator, both blocks reset together:
  - `frame_start` fires 1 cycle after release, then every 416800 cycles.
  - `locked` rises at cycle 833602 with `h_total=800`, `v_total=521`.
- While locked, generator at `X=0,Y=0`:
  - Decoder shows `x=0`, `y=0`, `active=1` one cycle later.
  - At `X=639,Y=479`, `x=639`, `y=479`.
  - Blanking gives `active=0` and `x=y=0`.
- While locked, stretch one line to 801 clocks → `locked=0` one cycle after that `hfall`. Relock after 2 further clean frames.
- Hold `hsync` high → `hc` saturates at 1023 → `locked` drops. Counters stay at 1023, with no wrap.
- Drive `vsync` with 520-line frames after lock → drop on the first 520-line `vfall` → relock with `v_total=520`.
- Assert `clr` mid-frame while locked:
  - All outputs read 0 the same cycle.
  - After release, lock is reacquired after 2 full frames.
